// File: rtl/dff_delay_line.sv
// dff_delay_line: WIDTH-bit, DEPTH-stage registered delay line with valid
// tracking. It is the parameterised successor to a single-bit D flip-flop.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; data <= RST_VAL, valids cleared
//   en         shift enable (0 = stall, every stage holds)
//   clr        synchronous flush of all valid bits; data is left untouched
//   din_valid  qualifies din
//   din        data into stage 0
//   dout_valid valid bit of the last stage
//   dout       data of the last stage (registered, no path from din)
//   fill_count number of stages currently holding valid data
//
// Priority at each clock edge: rst > clr > en > hold.
module dff_delay_line #(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       clr,
  input  logic                       din_valid,
  input  logic [WIDTH-1:0]           din,
  output logic                       dout_valid,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] fill_count
);

  localparam int unsigned FCW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) data[k] <= RST_VAL;
      vld        <= '0;
      fill_count <= '0;
    end else if (clr) begin
      vld        <= '0;
      fill_count <= '0;
    end else if (en) begin
      data[0] <= din;
      vld[0]  <= din_valid;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        data[k] <= data[k-1];
        vld[k]  <= vld[k-1];
      end
      // The last stage being valid guarantees fill_count >= 1, so the
      // subtraction never wraps; accept-and-emit leaves the count unchanged.
      fill_count <= fill_count + FCW'(din_valid) - FCW'(vld[DEPTH-1]);
    end
  end

  assign dout       = data[DEPTH-1];
  assign dout_valid = vld[DEPTH-1];

  // Consecutive edges with a plain shift (no rst/clr, en=1), saturating at
  // DEPTH; only the latency check below uses it.
  logic [FCW-1:0] a5_run;

  always_ff @(posedge clk) begin
    if (rst || clr || !en)          a5_run <= '0;
    else if (a5_run != FCW'(DEPTH)) a5_run <= a5_run + FCW'(1);
  end

  a1_reset: assert property (@(posedge clk) disable iff (rst)
    $past(rst) |-> (dout == RST_VAL && !dout_valid && fill_count == '0))
    else $error("A1 reset state violated at %0t", $time);

  a2_hold: assert property (@(posedge clk) disable iff (rst)
    $past(!en && !rst && !clr) |->
      (dout == $past(dout) && dout_valid == $past(dout_valid)))
    else $error("A2 hold violated at %0t", $time);

  a3_popcount: assert property (@(posedge clk) disable iff (rst)
    fill_count == FCW'($countones(vld)))
    else $error("A3 fill_count/popcount mismatch at %0t", $time);

  a4_bound: assert property (@(posedge clk) disable iff (rst)
    fill_count <= FCW'(DEPTH))
    else $error("A4 fill_count exceeds DEPTH at %0t", $time);

  a5_latency: assert property (@(posedge clk) disable iff (rst)
    a5_run == FCW'(DEPTH) |-> dout == $past(din, DEPTH))
    else $error("A5 latency violated at %0t", $time);

endmodule
